// File: rtl/nfc_seq_pkg.sv
// Shared constants, request/state encodings and small helpers for the NAND way sequencer.
package nfc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL_WAY,
    SET_ROW,
    ISSUE_OP,
    ISSUE_STS,
    WAIT_STS,
    RESP
  } seqState_t;

  typedef enum logic [1:0] {
    OP_PROGRAM       = 2'd0,
    OP_CACHE_PROGRAM = 2'd1,
    OP_READ          = 2'd2,
    OP_ERASE         = 2'd3
  } reqOp_t;

  localparam logic [5:0] OPC_SEL_WAY = 6'b100000;
  localparam logic [5:0] OPC_SET_ROW = 6'b100100;
  localparam logic [5:0] OPC_PROGRAM = 6'b000011;
  localparam logic [5:0] OPC_READ    = 6'b000100;
  localparam logic [5:0] OPC_ERASE   = 6'b000110;
  localparam logic [5:0] OPC_STATUS  = 6'b000111;

  localparam logic [4:0] TGT_NONE   = 5'b00000;
  localparam logic [4:0] TGT_CACHE  = 5'b00001;
  localparam logic [4:0] TGT_STATUS = 5'b00100;
  localparam logic [4:0] TGT_ARRAY  = 5'b00101;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  targetId;
    logic [31:0] address;
    logic [15:0] length;
  } cmdFields_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] targetId;
  } opTarget_t;

  function automatic opTarget_t opCommand(reqOp_t op);
    opTarget_t result;
    case (op)
      OP_PROGRAM:       result = '{opcode: OPC_PROGRAM, targetId: TGT_NONE};
      OP_CACHE_PROGRAM: result = '{opcode: OPC_PROGRAM, targetId: TGT_CACHE};
      OP_READ:          result = '{opcode: OPC_READ,    targetId: TGT_ARRAY};
      default:          result = '{opcode: OPC_ERASE,   targetId: TGT_ARRAY};
    endcase
    return result;
  endfunction

  // Cache program and read finish on RDY; program and erase must wait for ARDY.
  function automatic logic isComplete(reqOp_t op, logic [7:0] status);
    return ((op == OP_CACHE_PROGRAM) || (op == OP_READ)) ? status[6] : status[5];
  endfunction

endpackage

// File: rtl/nfc_seq_poll_counter.sv
// Saturating status-poll counter with a limit-reached flag for the way sequencer.
module nfc_seq_poll_counter #(
  parameter int PollLimit = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_increment,
  output logic o_limitReached
);

  localparam int CountWidth = $clog2(PollLimit + 1);
  localparam logic [CountWidth-1:0] LimitValue = CountWidth'(PollLimit);

  logic [CountWidth-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_increment && (r_count != LimitValue)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_limitReached = (r_count == LimitValue);

endmodule

// File: rtl/nfc_way_sequencer.sv
// Sequences way select, row set, operation and status polling towards the NAND controller.
// Optional build macro NFC_SEQ_TIMEOUT_EN turns the poll limit into an error response.
module nfc_way_sequencer
  import nfc_seq_pkg::*;
#(
  parameter int          NumberOfWays = 2,
  parameter int          PollLimit    = 1024,
  parameter logic [15:0] StatusLength = 16'h0008
) (
  input  logic        iSystemClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [1:0]  iReqOp,
  input  logic [7:0]  iReqWay,
  input  logic [23:0] iReqRow,
  output logic        oCMDValid,
  input  logic        iCMDReady,
  output logic [5:0]  oOpcode,
  output logic [4:0]  oTargetID,
  output logic [4:0]  oSourceID,
  output logic [31:0] oAddress,
  output logic [15:0] oLength,
  input  logic [15:0] iReadData,
  input  logic        iReadValid,
  output logic        oReadReady,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [7:0]  oRspStatus,
  output logic        oRspError,
  output logic        oBusy
);

`ifdef NFC_SEQ_TIMEOUT_EN
  localparam bit TimeoutEnable = 1'b1;
`else
  localparam bit TimeoutEnable = 1'b0;
`endif

  seqState_t  r_state;
  seqState_t  w_nextState;
  reqOp_t     r_op;
  logic [7:0] r_way;
  logic [23:0] r_row;
  logic [7:0] r_status;
  logic       r_cmdValid;
  logic       r_readReady;
  logic       r_rspValid;
  logic       r_rspError;
  logic [7:0] r_rspStatus;
  cmdFields_t r_cmd;
  cmdFields_t w_cmd;
  opTarget_t  w_opTarget;
  logic       w_accept;
  logic       w_badWay;
  logic       w_readBeat;
  logic       w_complete;
  logic       w_pollInc;
  logic       w_limitReached;
  logic       w_timeout;
  logic       w_unusedReadHigh;

  assign w_accept   = (r_state == IDLE) && iReqValid;
  assign w_badWay   = int'({24'd0, iReqWay}) >= NumberOfWays;
  assign w_readBeat = (r_state == WAIT_STS) && r_readReady && iReadValid;
  assign w_complete = isComplete(r_op, iReadData[7:0]);
  assign w_pollInc  = w_readBeat && !w_complete;
  assign w_timeout  = TimeoutEnable && (r_state == ISSUE_STS) && !r_cmdValid && w_limitReached;
  assign w_opTarget = opCommand(r_op);
  assign w_unusedReadHigh = ^iReadData[15:8];

  nfc_seq_poll_counter #(
    .PollLimit(PollLimit)
  ) u_pollCounter (
    .i_clock       (iSystemClock),
    .i_reset       (iReset),
    .i_clear       (w_accept),
    .i_increment   (w_pollInc),
    .o_limitReached(w_limitReached)
  );

  always_comb begin
    w_cmd       = '0;
    w_nextState = IDLE;
    case (r_state)
      SEL_WAY: begin
        w_cmd.opcode  = OPC_SEL_WAY;
        w_cmd.address = {24'd0, r_way};
        w_nextState   = SET_ROW;
      end
      SET_ROW: begin
        w_cmd.opcode  = OPC_SET_ROW;
        w_cmd.address = {8'd0, r_row};
        w_nextState   = ISSUE_OP;
      end
      ISSUE_OP: begin
        w_cmd.opcode   = w_opTarget.opcode;
        w_cmd.targetId = w_opTarget.targetId;
        w_cmd.address  = {8'd0, r_row};
        w_cmd.length   = StatusLength;
        w_nextState    = ISSUE_STS;
      end
      ISSUE_STS: begin
        w_cmd.opcode   = OPC_STATUS;
        w_cmd.targetId = TGT_STATUS;
        w_cmd.length   = StatusLength;
        w_nextState    = WAIT_STS;
      end
      default: ;
    endcase
  end

  // A command is raised only after ready was seen with valid low, and valid drops for a cycle after each transfer.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state     <= IDLE;
      r_op        <= OP_PROGRAM;
      r_way       <= '0;
      r_row       <= '0;
      r_status    <= '0;
      r_cmdValid  <= 1'b0;
      r_readReady <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspError  <= 1'b0;
      r_rspStatus <= '0;
      r_cmd       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= reqOp_t'(iReqOp);
            r_way       <= iReqWay;
            r_row       <= iReqRow;
            r_rspError  <= w_badWay;
            r_rspStatus <= '0;
            if (w_badWay) begin
              r_rspValid <= 1'b1;
              r_state    <= RESP;
            end else begin
              r_state <= SEL_WAY;
            end
          end
        end
        SEL_WAY, SET_ROW, ISSUE_OP, ISSUE_STS: begin
          if (w_timeout) begin
            r_rspValid  <= 1'b1;
            r_rspError  <= 1'b1;
            r_rspStatus <= r_status;
            r_state     <= RESP;
          end else if (!r_cmdValid) begin
            if (iCMDReady) begin
              r_cmdValid <= 1'b1;
              r_cmd      <= w_cmd;
            end
          end else if (iCMDReady) begin
            r_cmdValid <= 1'b0;
            r_state    <= w_nextState;
            if (w_nextState == WAIT_STS) begin
              r_readReady <= 1'b1;
            end
          end
        end
        WAIT_STS: begin
          if (w_readBeat) begin
            r_readReady <= 1'b0;
            r_status    <= iReadData[7:0];
            if (w_complete) begin
              r_rspValid  <= 1'b1;
              r_rspError  <= 1'b0;
              r_rspStatus <= iReadData[7:0];
              r_state     <= RESP;
            end else begin
              r_state <= ISSUE_STS;
            end
          end
        end
        RESP: begin
          if (iRspReady) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oReqReady  = (r_state == IDLE) && !iReset;
  assign oBusy      = (r_state != IDLE);
  assign oCMDValid  = r_cmdValid;
  assign oOpcode    = r_cmd.opcode;
  assign oTargetID  = r_cmd.targetId;
  assign oSourceID  = '0;
  assign oAddress   = r_cmd.address;
  assign oLength    = r_cmd.length;
  assign oReadReady = r_readReady;
  assign oRspValid  = r_rspValid;
  assign oRspStatus = r_rspStatus;
  assign oRspError  = r_rspError;

endmodule

// File: tb/tb_nfc_way_sequencer.sv
// Self-checking bench for nfc_way_sequencer: directed cases plus randomized requests against a transaction model.
module tb_nfc_way_sequencer;

  localparam int          Ways   = 2;
  localparam int          Limit  = 4;
  localparam logic [15:0] StsLen = 16'h0008;
`ifdef NFC_SEQ_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic        iSystemClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic [1:0]  iReqOp = '0;
  logic [7:0]  iReqWay = '0;
  logic [23:0] iReqRow = '0;
  logic        oCMDValid;
  logic        iCMDReady = 1'b0;
  logic [5:0]  oOpcode;
  logic [4:0]  oTargetID;
  logic [4:0]  oSourceID;
  logic [31:0] oAddress;
  logic [15:0] oLength;
  logic [15:0] iReadData = '0;
  logic        iReadValid = 1'b0;
  logic        oReadReady;
  logic        oRspValid;
  logic        iRspReady = 1'b0;
  logic [7:0]  oRspStatus;
  logic        oRspError;
  logic        oBusy;

  nfc_way_sequencer #(
    .NumberOfWays(Ways),
    .PollLimit   (Limit),
    .StatusLength(StsLen)
  ) dut (
    .iSystemClock(iSystemClock),
    .iReset      (iReset),
    .iReqValid   (iReqValid),
    .oReqReady   (oReqReady),
    .iReqOp      (iReqOp),
    .iReqWay     (iReqWay),
    .iReqRow     (iReqRow),
    .oCMDValid   (oCMDValid),
    .iCMDReady   (iCMDReady),
    .oOpcode     (oOpcode),
    .oTargetID   (oTargetID),
    .oSourceID   (oSourceID),
    .oAddress    (oAddress),
    .oLength     (oLength),
    .iReadData   (iReadData),
    .iReadValid  (iReadValid),
    .oReadReady  (oReadReady),
    .oRspValid   (oRspValid),
    .iRspReady   (iRspReady),
    .oRspStatus  (oRspStatus),
    .oRspError   (oRspError),
    .oBusy       (oBusy)
  );

  always #5 iSystemClock = ~iSystemClock;

  typedef struct {
    logic [5:0]  opcode;
    logic [4:0]  target;
    logic [31:0] address;
    logic [15:0] length;
    bit          chkAddr;
    bit          chkLen;
  } cmdRec_t;

  cmdRec_t    expCmds[$];
  cmdRec_t    obsCmds[$];
  logic [7:0] beats[$];
  logic       expErr;
  logic [7:0] expStatus;
  logic       obsErr;
  logic [7:0] obsStatus;
  bit         gotRsp;
  bit         randomReady;
  int         stallSetRow;
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic cmdRec_t mkCmd(logic [5:0] opc, logic [4:0] tgt, logic [31:0] addr,
                                    logic [15:0] len, bit ca, bit cl);
    cmdRec_t c;
    c.opcode = opc; c.target = tgt; c.address = addr; c.length = len;
    c.chkAddr = ca; c.chkLen = cl;
    return c;
  endfunction

  function automatic int completionBit(input int op);
    return (op == 1 || op == 2) ? 6 : 5;
  endfunction

  // Status beats: nFail random bytes with the completion bit clear, then one with it set.
  task automatic makeBeats(input int op, input int nFail);
    logic [7:0] b;
    int bitIdx;
    bitIdx = completionBit(op);
    beats.delete();
    for (int i = 0; i < nFail; i++) begin
      b = 8'($urandom);
      b[bitIdx] = 1'b0;
      beats.push_back(b);
    end
    b = 8'($urandom);
    b[bitIdx] = 1'b1;
    beats.push_back(b);
  endtask

  // Transaction-level model: the command list and response a request should produce.
  task automatic buildExpectation(input int op, input int way, input logic [23:0] row);
    int bitIdx;
    int fails;
    logic [5:0] opc;
    logic [4:0] tgt;
    expCmds.delete();
    expErr = 1'b0;
    expStatus = 8'h00;
    if (way >= Ways) begin
      expErr = 1'b1;
      return;
    end
    case (op)
      0: begin opc = 6'b000011; tgt = 5'b00000; end
      1: begin opc = 6'b000011; tgt = 5'b00001; end
      2: begin opc = 6'b000100; tgt = 5'b00101; end
      default: begin opc = 6'b000110; tgt = 5'b00101; end
    endcase
    expCmds.push_back(mkCmd(6'b100000, 5'd0, 32'(way), 16'h0, 1'b1, 1'b0));
    expCmds.push_back(mkCmd(6'b100100, 5'd0, {8'd0, row}, 16'h0, 1'b1, 1'b0));
    expCmds.push_back(mkCmd(opc, tgt, 32'h0, StsLen, 1'b0, 1'b1));
    bitIdx = completionBit(op);
    fails = 0;
    foreach (beats[i]) begin
      expCmds.push_back(mkCmd(6'b000111, 5'b00100, 32'h0, StsLen, 1'b0, 1'b1));
      if (beats[i][bitIdx]) begin
        expStatus = beats[i];
        return;
      end
      fails++;
      if (TimeoutOn && fails == Limit) begin
        expErr = 1'b1;
        expStatus = beats[i];
        return;
      end
    end
  endtask

  // Issues one request and plays controller/host until the response is taken (or WAIT_STS is reached when aborting).
  task automatic applyStimulus(input int op, input int way, input logic [23:0] row,
                               input bit abortAtWait, output bit reached);
    int cycles, beatIdx, stallCount, firstRsp;
    bit ready, prevValid, prevReady, prevTransfer, sawValid;
    logic [58:0] prevFields;
    reached = 1'b0;
    buildExpectation(op, way, row);
    checkOutput("reqReady", oReqReady, 1'b1);
    iReqValid = 1'b1;
    iReqOp = op[1:0];
    iReqWay = way[7:0];
    iReqRow = row;
    @(posedge iSystemClock);
    @(negedge iSystemClock);
    iReqValid = 1'b0;
    obsCmds.delete();
    gotRsp = 1'b0;
    cycles = 0; beatIdx = 0; stallCount = 0; firstRsp = -1;
    prevValid = 1'b0; prevReady = 1'b0; prevTransfer = 1'b0; sawValid = 1'b0;
    prevFields = '0;
    while (!gotRsp && cycles < 3000) begin
      if (abortAtWait && oReadReady) begin
        reached = 1'b1;
        break;
      end
      if (oCMDValid) sawValid = 1'b1;
      if (prevTransfer) checkOutput("cmdGap", oCMDValid, 1'b0);
      if (oCMDValid && !prevValid) checkOutput("readyBeforeValid", prevReady, 1'b1);
      if (prevValid && !prevReady)
        checkOutput("cmdStable", {oCMDValid, oOpcode, oTargetID, oAddress, oLength}, {1'b1, prevFields});
      ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (oCMDValid && oOpcode == 6'b100100 && stallCount < stallSetRow) begin
        ready = 1'b0;
        stallCount++;
      end
      iCMDReady = ready;
      if (oCMDValid && ready) obsCmds.push_back(mkCmd(oOpcode, oTargetID, oAddress, oLength, 1'b0, 1'b0));
      iReadValid = 1'b0;
      if (oReadReady && (!randomReady || $urandom_range(0, 1) == 1)) begin
        iReadValid = 1'b1;
        iReadData = {8'($urandom), (beatIdx < beats.size()) ? beats[beatIdx] : 8'h00};
        beatIdx++;
      end
      iRspReady = 1'b0;
      if (oRspValid) begin
        if (firstRsp < 0) firstRsp = cycles;
        if (!randomReady || $urandom_range(0, 1) == 1) begin
          iRspReady = 1'b1;
          obsErr = oRspError;
          obsStatus = oRspStatus;
          gotRsp = 1'b1;
        end
      end
      prevValid = oCMDValid;
      prevReady = ready;
      prevTransfer = oCMDValid && ready;
      prevFields = {oOpcode, oTargetID, oAddress, oLength};
      @(posedge iSystemClock);
      @(negedge iSystemClock);
      cycles++;
    end
    iCMDReady = 1'b0;
    iReadValid = 1'b0;
    iRspReady = 1'b0;
    if (abortAtWait) return;
    checkOutput("rspSeen", gotRsp, 1'b1);
    checkOutput("idleAfterRsp", {oBusy, oRspValid}, 2'b00);
    checkOutput("cmdCount", obsCmds.size(), expCmds.size());
    for (int i = 0; i < expCmds.size() && i < obsCmds.size(); i++) begin
      checkOutput($sformatf("cmd%0d.opcode", i), obsCmds[i].opcode, expCmds[i].opcode);
      checkOutput($sformatf("cmd%0d.target", i), obsCmds[i].target, expCmds[i].target);
      if (expCmds[i].chkAddr) checkOutput($sformatf("cmd%0d.address", i), obsCmds[i].address, expCmds[i].address);
      if (expCmds[i].chkLen) checkOutput($sformatf("cmd%0d.length", i), obsCmds[i].length, expCmds[i].length);
    end
    checkOutput("rspError", obsErr, expErr);
    checkOutput("rspStatus", obsStatus, expStatus);
    if (way >= Ways) begin
      checkOutput("badWayNoCmdValid", sawValid, 1'b0);
      checkOutput("badWayLatency", (firstRsp >= 0 && firstRsp <= 1), 1'b1);
    end
  endtask

  initial begin
    bit reached;
    int op, way, nFail;
    logic [23:0] row;
    randomReady = 1'b0;
    stallSetRow = 0;

    $display("[TB] reset state");
    repeat (3) @(negedge iSystemClock);
    checkOutput("resetOutputs",
                {oCMDValid, oReadReady, oRspValid, oRspError, oRspStatus, oBusy, oReqReady,
                 oOpcode, oTargetID, oSourceID, oAddress, oLength}, '0);
    iReset = 1'b0;
    #1;
    checkOutput("reqReadyAfterReset", oReqReady, 1'b1);
    @(negedge iSystemClock);

    $display("[TB] program way 1 row 0, two polls");
    beats.delete(); beats.push_back(8'h00); beats.push_back(8'h20);
    applyStimulus(0, 1, 24'h0, 1'b0, reached);

    $display("[TB] cache program, ready on first poll");
    beats.delete(); beats.push_back(8'h40);
    applyStimulus(1, 0, 24'h00_1234, 1'b0, reached);

    $display("[TB] bad way");
    beats.delete();
    applyStimulus(0, 2, 24'h0, 1'b0, reached);

    $display("[TB] SET_ROW stalled five cycles");
    stallSetRow = 5;
    beats.delete(); beats.push_back(8'h20);
    applyStimulus(0, 1, 24'hABCDEF, 1'b0, reached);
    stallSetRow = 0;

    $display("[TB] status never completes");
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(8'h00);
    if (!TimeoutOn) beats.push_back(8'h20);
    applyStimulus(0, 0, 24'h000010, 1'b0, reached);

    $display("[TB] reset during WAIT_STS");
    beats.delete(); beats.push_back(8'h20);
    applyStimulus(3, 1, 24'h000777, 1'b1, reached);
    checkOutput("reachedWaitSts", reached, 1'b1);
    iReset = 1'b1;
    @(posedge iSystemClock);
    @(negedge iSystemClock);
    checkOutput("abortOutputs", {oCMDValid, oRspValid, oBusy, oReadReady}, 4'b0000);
    iReset = 1'b0;
    #1;
    checkOutput("reqReadyAfterAbort", oReqReady, 1'b1);
    beats.delete(); beats.push_back(8'h60);
    applyStimulus(2, 0, 24'h00BEEF, 1'b0, reached);

    $display("[TB] randomized requests");
    randomReady = 1'b1;
    for (int n = 0; n < 25; n++) begin
      op = $urandom_range(0, 3);
      way = $urandom_range(0, Ways);
      row = 24'($urandom);
      nFail = $urandom_range(0, 5);
      makeBeats(op, nFail);
      applyStimulus(op, way, row, 1'b0, reached);
      repeat ($urandom_range(0, 2)) @(negedge iSystemClock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
